// File: rtl/clk_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_period_meter_pkg
//
// Purpose:
//   Shared definitions for the divided-clock period meter: the measurement
//   state encoding and the default counter / synchroniser sizes.
//
// Contents:
//   CNT_W_DEF        default width of the period counter and PERIOD output
//   SYNC_STAGES_DEF  default depth of the DIV_CLK synchroniser (legal 1..3)
//   meas_state_e     IDLE / ARM / MEASURE state encoding
//
// Optional feature macro used by the block: CLK_PERIOD_METER_DUTY_EN
// -----------------------------------------------------------------------------
package clk_period_meter_pkg;

   localparam int CNT_W_DEF       = 8;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } meas_state_e;

endpackage : clk_period_meter_pkg

// File: rtl/clk_period_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
//
// Purpose:
//   Brings an asynchronous-looking level (e.g. a divided clock) into the
//   clk_i domain through a SYNC_STAGES flop chain, then detects its edges
//   with one extra history flop. Reusable by any consumer of the divider.
//
// Parameters:
//   SYNC_STAGES  number of synchroniser flops, legal range 1..3
//   FALL_EN      1 = produce fall_o, 0 = fall_o tied low (no fall logic)
//
// Ports:
//   clk_i    in   sampling clock
//   rst_ni   in   synchronous active-low reset (clears chain and history)
//   d_i      in   level to be sampled
//   sync_o   out  synchronised level (last chain flop)
//   rise_o   out  one-cycle pulse: sync_o=1 while history=0
//   fall_o   out  one-cycle pulse: sync_o=0 while history=1 (FALL_EN only)
// -----------------------------------------------------------------------------
module edge_sync #(
   parameter int SYNC_STAGES = 2,
   parameter bit FALL_EN     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;

   // Shift the sampled level one flop deeper every cycle.
   always_comb begin
      sync_d    = '0;
      sync_d[0] = d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

   generate
      if (FALL_EN) begin : g_fall
         assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;
      end else begin : g_no_fall
         assign fall_o = 1'b0;
      end
   endgenerate

endmodule : edge_sync

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Purpose:
//   Measures the period of a divided clock (sampled as data) in CLK_IN
//   cycles and offers each result to a consumer on a valid/ack handshake.
//   Flags counter saturation (no edge seen) and dropped results.
//
// Parameters:
//   CNT_W        counter / PERIOD width; saturation value 2^CNT_W-1
//   SYNC_STAGES  DIV_CLK synchroniser depth, legal 1..3
//
// Ports:
//   CLK_IN        in   system clock (only clock)
//   RST_N         in   synchronous active-low reset
//   DIV_CLK       in   divided clock, sampled as data
//   MEAS_EN       in   measurement enable; 0 forces IDLE
//   PERIOD_ACK    in   consumer accepts the current result
//   PERIOD        out  last accepted-slot period, CLK_IN cycles
//   PERIOD_VALID  out  PERIOD holds an unaccepted result
//   OVERFLOW      out  sticky: counter saturated with no DIV_CLK rise
//   MISSED        out  sticky: result dropped while VALID=1 and ACK=0
//   HIGH_TIME     out  high phase length of the measured period
//                      (only when CLK_PERIOD_METER_DUTY_EN is defined)
//
// Optional feature macro: CLK_PERIOD_METER_DUTY_EN
// -----------------------------------------------------------------------------
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             CLK_IN,
   input  logic             RST_N,
   input  logic             DIV_CLK,
   input  logic             MEAS_EN,
   input  logic             PERIOD_ACK,
   output logic [CNT_W-1:0] PERIOD,
   output logic             PERIOD_VALID,
   output logic             OVERFLOW,
   output logic             MISSED
`ifdef CLK_PERIOD_METER_DUTY_EN
   ,
   output logic [CNT_W-1:0] HIGH_TIME
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Saturating increment of the period counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   meas_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] period_q;
   logic             valid_q;
   logic             ovf_q;
   logic             missed_q;

   logic             rise_pulse;
   logic             sync_lvl;
   logic             result_d;
   logic             load_d;
   logic             drop_d;

   // ---------------------------------------------------------------------
   // DIV_CLK synchroniser and edge detect
   // ---------------------------------------------------------------------
`ifdef CLK_PERIOD_METER_DUTY_EN
   logic             fall_pulse;
   logic [CNT_W-1:0] hi_cap_q;
   logic [CNT_W-1:0] high_q;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FALL_EN     (1'b1)
   ) u_edge_sync (
      .clk_i  (CLK_IN),
      .rst_ni (RST_N),
      .d_i    (DIV_CLK),
      .sync_o (sync_lvl),
      .rise_o (rise_pulse),
      .fall_o (fall_pulse)
   );
`else
   logic unused_fall;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FALL_EN     (1'b0)
   ) u_edge_sync (
      .clk_i  (CLK_IN),
      .rst_ni (RST_N),
      .d_i    (DIV_CLK),
      .sync_o (sync_lvl),
      .rise_o (rise_pulse),
      .fall_o (unused_fall)
   );
`endif

   logic unused_sync_lvl;
   assign unused_sync_lvl = sync_lvl;

   // ---------------------------------------------------------------------
   // Result qualification: a rise in MEASURE completes one period. Disabling
   // the block wins over a coincident rise.
   // ---------------------------------------------------------------------
   always_comb begin
      result_d = MEAS_EN && (state_q == MEASURE) && rise_pulse;
      load_d   = result_d && (!valid_q || PERIOD_ACK);
      drop_d   = result_d && valid_q && !PERIOD_ACK;
   end

   // ---------------------------------------------------------------------
   // Measurement FSM, counter and handshake registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         missed_q <= 1'b0;
      end else if (!MEAS_EN) begin
         // PERIOD and the sticky flags are held for inspection.
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q    <= '0;
               state_q  <= ARM;
               ovf_q    <= 1'b0;
               missed_q <= 1'b0;
            end
            ARM: begin
               // The first rise only starts the count; it closes no period.
               if (rise_pulse) begin
                  cnt_q   <= CNT_ONE;
                  state_q <= MEASURE;
               end
            end
            MEASURE: begin
               if (rise_pulse) begin
                  // Counter is 1 in the cycle after a rise, so it equals P
                  // in the cycle of the next rise P cycles later.
                  cnt_q <= CNT_ONE;
               end else if (cnt_q == CNT_MAX) begin
                  ovf_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ARM;
               end else begin
                  cnt_q <= sat_inc(cnt_q);
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase

         if (load_d) begin
            period_q <= cnt_q;
            valid_q  <= 1'b1;
         end else if (PERIOD_ACK) begin
            valid_q <= 1'b0;
         end

         if (drop_d) begin
            missed_q <= 1'b1;
         end
      end
   end

`ifdef CLK_PERIOD_METER_DUTY_EN
   // ---------------------------------------------------------------------
   // High-time capture: the counter value at the fall is the number of
   // cycles since the preceding rise; it is published with the period.
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         hi_cap_q <= '0;
         high_q   <= '0;
      end else begin
         if (MEAS_EN && (state_q == MEASURE) && fall_pulse) begin
            hi_cap_q <= cnt_q;
         end
         if (load_d) begin
            high_q <= hi_cap_q;
         end
      end
   end

   assign HIGH_TIME = high_q;
`endif

   assign PERIOD       = period_q;
   assign PERIOD_VALID = valid_q;
   assign OVERFLOW     = ovf_q;
   assign MISSED       = missed_q;

endmodule : clk_period_meter
